k007232_gen: RTL

Parametrised successor of the two-channel PCM playback engine. It provides NCH time-multiplexed sample channels sharing one external sample ROM bus, each channel with a configurable address width and prescaler width. New over the fixed two-channel block: an arbitrary channel count, a separate per-channel loop address, explicit stop, a busy/status vector and per-channel sample strobes. Everything sits in a single clock domain; the block feeds per-channel 7-bit sample values to the downstream mixer/DAC logic.

---
 rtl/k007232_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/k007232_gen.sv
// NCH-channel time-multiplexed PCM playback engine sharing one sample ROM bus.
// Each slot fetches at edge t and is processed with the returned ROM byte at edge t+1.
module k007232_gen #(
    parameter int unsigned NCH = 2,
    parameter int unsigned AW  = 17,
    parameter int unsigned PW  = 12,
    localparam int unsigned CW = $clog2(NCH)
) (
    input  logic               CLK,
    input  logic               RES,
    input  logic               WE,
    input  logic [CW+2:0]      AB,
    input  logic [7:0]         DB,
    output logic [AW-1:0]      SA,
    output logic [CW-1:0]      SCH,
    input  logic [7:0]         SD,
    output logic [7*NCH-1:0]   OUT,
    output logic [NCH-1:0]     SMP,
    output logic [NCH-1:0]     BUSY
);

    logic [PW-1:0] r_pitch [NCH];
    logic [AW-1:0] r_start [NCH];
    logic [AW-1:0] r_loop  [NCH];
    logic [2:0]    r_mode  [NCH];
    logic [AW-1:0] r_addr  [NCH];
    logic [PW-1:0] r_pre   [NCH];
    logic [6:0]    r_out   [NCH];
    logic [NCH-1:0] r_busy;
    logic [NCH-1:0] r_smp;
    logic [AW-1:0]  r_sa;
    logic [CW-1:0]  r_sch;
    logic [CW-1:0]  r_slot;
    logic           r_pv;

    logic [CW-1:0] w_ch;
    logic [2:0]    w_off;
    logic          w_wr;
    logic          w_trig;
    logic          w_stop;
    logic          w_coll;
    logic [AW-1:0] w_abase;
    logic [AW-1:0] w_anew;
    logic [PW-1:0] w_pnew;

    assign w_ch    = AB[CW+2:3];
    assign w_off   = AB[2:0];
    assign w_wr    = WE && (32'(w_ch) < NCH);
    assign w_trig  = w_wr && (w_off == 3'd6);
    assign w_stop  = w_wr && (w_off == 3'd7);
    assign w_coll  = (w_trig || w_stop) && r_pv && (w_ch == r_sch);
    assign w_abase = r_mode[w_ch][2] ? r_loop[w_ch] : r_start[w_ch];

    always_comb begin
        case (w_off)
            3'd0:    w_pnew = {r_pitch[w_ch][PW-1:8], DB};
            3'd1:    w_pnew = {DB[PW-9:0], r_pitch[w_ch][7:0]};
            default: w_pnew = r_pitch[w_ch];
        endcase
    end

    // Byte lanes above AW are dropped; the upper-byte lane only exists for AW > 16.
    if (AW > 16) begin : g_wide
        always_comb begin
            case (w_off)
                3'd2:    w_anew = {w_abase[AW-1:8], DB};
                3'd3:    w_anew = {w_abase[AW-1:16], DB, w_abase[7:0]};
                3'd4:    w_anew = {DB[AW-17:0], w_abase[15:0]};
                default: w_anew = w_abase;
            endcase
        end
    end else begin : g_narrow
        always_comb begin
            case (w_off)
                3'd2:    w_anew = {w_abase[AW-1:8], DB};
                3'd3:    w_anew = {DB[AW-9:0], w_abase[7:0]};
                default: w_anew = w_abase;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                r_pitch[i] <= '0;
                r_start[i] <= '0;
                r_loop[i]  <= '0;
                r_mode[i]  <= '0;
                r_addr[i]  <= '0;
                r_pre[i]   <= '0;
                r_out[i]   <= '0;
            end
            r_busy <= '0;
            r_smp  <= '0;
            r_sa   <= '0;
            r_sch  <= '0;
            r_slot <= '0;
            r_pv   <= 1'b0;
        end else begin
            r_smp  <= '0;
            r_pv   <= 1'b1;
            r_sch  <= r_slot;
            r_slot <= (32'(r_slot) == NCH - 1) ? '0 : r_slot + 1'b1;
            // A trigger landing on the fetch edge presents the new start at once.
            r_sa   <= (w_trig && (w_ch == r_slot)) ? r_start[r_slot] : r_addr[r_slot];

            if (r_pv && r_busy[r_sch] && !w_coll) begin
                if (SD[7]) begin
                    if (r_mode[r_sch][0]) begin
                        r_addr[r_sch] <= r_mode[r_sch][1] ? r_loop[r_sch] : r_start[r_sch];
                        r_pre[r_sch]  <= r_pitch[r_sch];
                    end else begin
                        r_busy[r_sch] <= 1'b0;
                    end
                end else begin
                    r_out[r_sch] <= SD[6:0];
                    r_smp[r_sch] <= 1'b1;
                    if (&r_pre[r_sch]) begin
                        r_pre[r_sch]  <= r_pitch[r_sch];
                        r_addr[r_sch] <= r_addr[r_sch] + 1'b1;
                    end else begin
                        r_pre[r_sch] <= r_pre[r_sch] + 1'b1;
                    end
                end
            end

            if (w_wr) begin
                case (w_off)
                    3'd0, 3'd1: r_pitch[w_ch] <= w_pnew;
                    3'd2, 3'd3, 3'd4: begin
                        if (r_mode[w_ch][2]) r_loop[w_ch]  <= w_anew;
                        else                 r_start[w_ch] <= w_anew;
                    end
                    3'd5: r_mode[w_ch] <= DB[2:0];
                    3'd6: begin
                        r_addr[w_ch] <= r_start[w_ch];
                        r_pre[w_ch]  <= r_pitch[w_ch];
                        r_busy[w_ch] <= 1'b1;
                    end
                    default: r_busy[w_ch] <= 1'b0;
                endcase
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign OUT[7*c+6:7*c] = r_out[c];
    end

    assign SA   = r_sa;
    assign SCH  = r_sch;
    assign SMP  = r_smp;
    assign BUSY = r_busy;

endmodule
